// File: rtl/sram_element_rmw.sv
// sram_element_rmw
//   Element-granular front end for one port of the block-wide cache SRAM.
//   Single-element reads return the selected element; single-element writes
//   become a block read-modify-write. Only one request is in flight at a time,
//   so back-to-back RMWs to the same block need no hazard logic.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   io_req_valid/ready    request handshake (ready only in IDLE)
//   io_req_write          1 = write element, 0 = read element
//   io_req_addr           {block index, element index}
//   io_req_data           element write data
//   io_resp_valid/ready   read response handshake (reads only)
//   io_resp_data          read element, held until consumed
//   io_sram_addr/we/din   drive the SRAM port (din is the merged block)
//   io_sram_dout          SRAM read data, valid one cycle after addr
module sram_element_rmw #(
  parameter int ELEMENT_WIDTH      = 32,
  parameter int ELEMENTS_PER_BLOCK = 4,
  parameter int LG_EPB             = 2,
  parameter int WIDTH              = 128,
  parameter int DEPTH              = 64,
  parameter int LG_DEPTH           = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_req_valid,
  output logic                       io_req_ready,
  input  logic                       io_req_write,
  input  logic [LG_DEPTH+LG_EPB-1:0] io_req_addr,
  input  logic [ELEMENT_WIDTH-1:0]   io_req_data,
  output logic                       io_resp_valid,
  input  logic                       io_resp_ready,
  output logic [ELEMENT_WIDTH-1:0]   io_resp_data,
  output logic [LG_DEPTH-1:0]        io_sram_addr,
  output logic                       io_sram_we,
  output logic [WIDTH-1:0]           io_sram_din,
  input  logic [WIDTH-1:0]           io_sram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  state_t                     r_state;
  logic                       r_write;
  logic [LG_EPB-1:0]          r_elem;
  logic [ELEMENT_WIDTH-1:0]   r_data;
  logic                       r_resp_valid;
  logic [ELEMENT_WIDTH-1:0]   r_resp_data;
  logic [LG_DEPTH-1:0]        r_sram_addr;
  logic                       r_sram_we;
  logic [WIDTH-1:0]           r_sram_din;

  logic [LG_DEPTH-1:0]        w_req_blk;
  logic [LG_EPB-1:0]          w_req_elem;

  assign w_req_blk  = io_req_addr[LG_DEPTH+LG_EPB-1:LG_EPB];
  assign w_req_elem = io_req_addr[LG_EPB-1:0];

  // Replace element idx of blk with d; other elements pass through unchanged.
  function automatic logic [WIDTH-1:0] f_merge(
    input logic [WIDTH-1:0]         blk,
    input logic [LG_EPB-1:0]        idx,
    input logic [ELEMENT_WIDTH-1:0] d
  );
    logic [WIDTH-1:0] m;
    m = blk;
    for (int i = 0; i < ELEMENTS_PER_BLOCK; i++) begin
      if (idx == LG_EPB'(i)) begin
        m[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = d;
      end
    end
    return m;
  endfunction

  function automatic logic [ELEMENT_WIDTH-1:0] f_select(
    input logic [WIDTH-1:0]  blk,
    input logic [LG_EPB-1:0] idx
  );
    logic [ELEMENT_WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < ELEMENTS_PER_BLOCK; i++) begin
      if (idx == LG_EPB'(i)) begin
        s = blk[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      end
    end
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      // Any in-flight request is dropped: no late write, no response.
      r_state      <= S_IDLE;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_sram_addr  <= '0;
      r_sram_we    <= 1'b0;
      r_sram_din   <= '0;
    end else begin
      case (r_state)
        // Accept: capture the request, present the block address.
        S_IDLE: begin
          if (io_req_valid) begin
            r_write     <= io_req_write;
            r_elem      <= w_req_elem;
            r_data      <= io_req_data;
            r_sram_addr <= w_req_blk;
            r_state     <= S_RD;
          end
        end
        // SRAM samples the address this cycle.
        S_RD: begin
          r_state <= S_CAP;
        end
        // Block data is on io_sram_dout: merge for a write, select for a read.
        S_CAP: begin
          if (r_write) begin
            r_sram_din <= f_merge(io_sram_dout, r_elem, r_data);
            r_sram_we  <= 1'b1;
            r_state    <= S_WR;
          end else begin
            r_resp_data  <= f_select(io_sram_dout, r_elem);
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
        end
        // Single-cycle write pulse; address is still held from accept.
        S_WR: begin
          r_sram_we <= 1'b0;
          r_state   <= S_IDLE;
        end
        // Hold the response until the consumer takes it.
        S_RESP: begin
          if (io_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_req_ready  = (r_state == S_IDLE);
  assign io_resp_valid = r_resp_valid;
  assign io_resp_data  = r_resp_data;
  assign io_sram_addr  = r_sram_addr;
  assign io_sram_we    = r_sram_we;
  assign io_sram_din   = r_sram_din;

endmodule

// File: tb/tb_sram_element_rmw.sv
// Testbench for sram_element_rmw: behavioural SRAM, element-array reference
// model, queue scoreboard with an independent monitor process.
module tb_sram_element_rmw;

  localparam int EW  = 32;
  localparam int EPB = 4;
  localparam int W   = 128;
  localparam int D   = 64;
  localparam int LGD = 6;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          io_req_valid;
  logic          io_req_ready;
  logic          io_req_write;
  logic [AW-1:0] io_req_addr;
  logic [EW-1:0] io_req_data;
  logic          io_resp_valid;
  logic          io_resp_ready;
  logic [EW-1:0] io_resp_data;
  logic [LGD-1:0] io_sram_addr;
  logic          io_sram_we;
  logic [W-1:0]  io_sram_din;
  logic [W-1:0]  io_sram_dout;

  always #5 clk = ~clk;

  sram_element_rmw dut (
    .clk          (clk),
    .reset        (reset),
    .io_req_valid (io_req_valid),
    .io_req_ready (io_req_ready),
    .io_req_write (io_req_write),
    .io_req_addr  (io_req_addr),
    .io_req_data  (io_req_data),
    .io_resp_valid(io_resp_valid),
    .io_resp_ready(io_resp_ready),
    .io_resp_data (io_resp_data),
    .io_sram_addr (io_sram_addr),
    .io_sram_we   (io_sram_we),
    .io_sram_din  (io_sram_din),
    .io_sram_dout (io_sram_dout)
  );

  // Reference model: flat array of elements, element address = request address.
  logic [EW-1:0] ref_el [D*EPB];
  logic [W-1:0]  mem [D];
  logic          pl_go;
  int            cyc;

  function automatic logic [W-1:0] ref_block(input int b);
    logic [W-1:0] r;
    for (int e = 0; e < EPB; e++) r[e*EW +: EW] = ref_el[b*EPB + e];
    return r;
  endfunction

  // Behavioural SRAM port: registered read, write on we.
  always @(posedge clk) begin
    if (pl_go) begin
      for (int b = 0; b < D; b++) mem[b] <= ref_block(b);
    end else if (io_sram_we) begin
      mem[io_sram_addr] <= io_sram_din;
    end
    io_sram_dout <= mem[io_sram_addr];
    cyc <= cyc + 1;
  end

  typedef struct packed {
    logic [LGD-1:0] a;
    logic [W-1:0]   d;
  } wr_t;

  wr_t           wq[$];
  logic [EW-1:0] rq[$];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // Monitor: compares every SRAM write and every consumed response with the queues.
  initial begin : monitor
    wr_t           e;
    logic [EW-1:0] r;
    forever begin
      @(negedge clk);
      if (io_sram_we) begin
        if (wq.size() == 0) fail("unexpected_we");
        else begin
          e = wq.pop_front();
          chk("wr_addr", W'(io_sram_addr), W'(e.a));
          chk("wr_din", io_sram_din, e.d);
        end
      end
      if (io_resp_valid && io_resp_ready) begin
        if (rq.size() == 0) fail("unexpected_resp");
        else begin
          r = rq.pop_front();
          chk("rd_data", W'(io_resp_data), W'(r));
        end
      end
    end
  end

  // Present a request and wait for acceptance; returns at posedge+1 of cycle T+1.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [EW-1:0] d,
                       input bit track, input bit keep, output int acc_cyc);
    bit got;
    got = 0;
    io_req_valid = 1'b1;
    io_req_write = wr;
    io_req_addr  = a;
    io_req_data  = d;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (io_req_ready) begin
        @(posedge clk);
        #1;
        got = 1;
      end
    end
    acc_cyc = cyc;
    if (!got) fail("accept_timeout");
    else if (track) begin
      if (wr) begin
        ref_el[a] = d;
        wq.push_back('{a: a[7:2], d: ref_block(int'(a[7:2]))});
      end else begin
        rq.push_back(ref_el[a]);
      end
    end
    if (!keep) io_req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    bit done;
    done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      io_resp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (io_resp_valid && io_resp_ready) done = 1;
      @(posedge clk);
      #1;
    end
    io_resp_ready = 1'b0;
    if (!done) fail("resp_timeout");
  endtask

  initial begin : stim
    int t0, t1;
    logic wr;
    logic [AW-1:0] a;
    reset = 1'b1;
    pl_go = 1'b1;
    io_req_valid = 1'b0;
    io_req_write = 1'b0;
    io_req_addr = '0;
    io_req_data = '0;
    io_resp_ready = 1'b0;
    for (int i = 0; i < D*EPB; i++) ref_el[i] = '0;
    ref_el[4] = 32'h11111111; ref_el[5] = 32'h22222222;
    ref_el[6] = 32'h33333333; ref_el[7] = 32'h44444444;
    for (int e = 0; e < EPB; e++) ref_el[252 + e] = 32'h63000000 + e;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    pl_go = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_req_ready", W'(io_req_ready), W'(1));
    chk("rst_resp_valid", W'(io_resp_valid), W'(0));
    chk("rst_we", W'(io_sram_we), W'(0));
    chk("rst_addr", W'(io_sram_addr), W'(0));
    chk("rst_din", io_sram_din, W'(0));
    chk("rst_resp_data", W'(io_resp_data), W'(0));
    @(posedge clk); #1;

    // 1: write addr 6 into preloaded block 1
    issue(1'b1, 8'd6, 32'hDEADBEEF, 1, 0, t0);
    @(negedge clk);
    chk("t1_T1_we", W'(io_sram_we), W'(0));
    chk("t1_T1_addr", W'(io_sram_addr), W'(1));
    chk("t1_T1_ready", W'(io_req_ready), W'(0));
    @(negedge clk);
    chk("t1_T2_we", W'(io_sram_we), W'(0));
    @(negedge clk);
    chk("t1_T3_we", W'(io_sram_we), W'(1));
    chk("t1_T3_addr", W'(io_sram_addr), W'(1));
    chk("t1_T3_din", io_sram_din, 128'h44444444_DEADBEEF_22222222_11111111);
    @(negedge clk);
    chk("t1_T4_we", W'(io_sram_we), W'(0));
    chk("t1_T4_ready", W'(io_req_ready), W'(1));
    chk("t1_mem", mem[1], 128'h44444444_DEADBEEF_22222222_11111111);
    @(posedge clk); #1;

    // 2: read it back, consumer always ready
    io_resp_ready = 1'b1;
    issue(1'b0, 8'd6, 32'h0, 1, 0, t0);
    @(negedge clk);
    chk("t2_T1_valid", W'(io_resp_valid), W'(0));
    chk("t2_T1_we", W'(io_sram_we), W'(0));
    @(negedge clk);
    chk("t2_T2_valid", W'(io_resp_valid), W'(0));
    chk("t2_T2_we", W'(io_sram_we), W'(0));
    @(negedge clk);
    chk("t2_T3_valid", W'(io_resp_valid), W'(1));
    chk("t2_T3_data", W'(io_resp_data), W'(32'hDEADBEEF));
    chk("t2_T3_we", W'(io_sram_we), W'(0));
    @(negedge clk);
    chk("t2_T4_ready", W'(io_req_ready), W'(1));
    chk("t2_T4_valid", W'(io_resp_valid), W'(0));
    @(posedge clk); #1;
    io_resp_ready = 1'b0;

    // 3: read with response stalled 5 cycles
    issue(1'b0, 8'd6, 32'h0, 1, 0, t0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_valid", W'(io_resp_valid), W'(1));
      chk("t3_hold_data", W'(io_resp_data), W'(32'hDEADBEEF));
      chk("t3_hold_ready", W'(io_req_ready), W'(0));
    end
    @(posedge clk); #1;
    io_resp_ready = 1'b1;
    @(negedge clk);
    chk("t3_hs_valid", W'(io_resp_valid), W'(1));
    @(posedge clk); #1;
    io_resp_ready = 1'b0;
    @(negedge clk);
    chk("t3_idle_ready", W'(io_req_ready), W'(1));
    chk("t3_idle_valid", W'(io_resp_valid), W'(0));
    @(posedge clk); #1;

    // 4: back-to-back writes to block 0, valid held high
    issue(1'b1, 8'd0, 32'hA5A50001, 1, 1, t0);
    issue(1'b1, 8'd3, 32'h5A5A0003, 1, 0, t1);
    chk("t4_gap", W'(t1 - t0), W'(4));
    repeat (4) @(posedge clk);
    #1;
    chk("t4_mem", mem[0], {32'h5A5A0003, 32'h0, 32'h0, 32'hA5A50001});

    // 5: reset during RD, then during CAP, of a write to block 2
    issue(1'b1, 8'd8, 32'hCAFEF00D, 0, 0, t0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5a_ready", W'(io_req_ready), W'(1));
    chk("t5a_we", W'(io_sram_we), W'(0));
    chk("t5a_addr", W'(io_sram_addr), W'(0));
    @(posedge clk); #1;
    issue(1'b1, 8'd9, 32'hCAFEF00D, 0, 0, t0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5b_ready", W'(io_req_ready), W'(1));
    chk("t5b_we", W'(io_sram_we), W'(0));
    chk("t5b_din", io_sram_din, W'(0));
    chk("t5b_resp_valid", W'(io_resp_valid), W'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("t5_mem", mem[2], W'(0));

    // 6: top element of the last block
    io_resp_ready = 1'b1;
    issue(1'b0, 8'd255, 32'h0, 1, 0, t0);
    @(negedge clk);
    chk("t6_addr", W'(io_sram_addr), W'(63));
    repeat (2) @(negedge clk);
    chk("t6_valid", W'(io_resp_valid), W'(1));
    chk("t6_data", W'(io_resp_data), W'(32'h63000003));
    @(posedge clk); #1;
    io_resp_ready = 1'b0;

    // Randomized traffic over a small address window for frequent reuse
    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      a = (n % 3 == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 31));
      issue(wr, a, $urandom, 1, 0, t0);
      if (!wr) wait_resp();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (10) @(posedge clk);
    #1;
    chk("end_wq_empty", W'(wq.size()), W'(0));
    chk("end_rq_empty", W'(rq.size()), W'(0));
    for (int b = 0; b < D; b++) chk("end_mem", mem[b], ref_block(b));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
